// File: rtl/dm_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: access size codes,
// FSM state encoding, the default error return value and the alignment rule.
package dm_lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_t;

   localparam logic [31:0] ERR_CODE_DEFAULT = 32'hDEAD;

   // A half must sit on an even byte, a word on a multiple of four.
   function automatic logic access_misaligned(input logic [1:0] size, input logic [1:0] off);
      return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Little-endian lane steering between a 32-bit DM word and the CPU.
// Load side extracts the addressed byte/half and extends it; store side
// replaces only the addressed lane of the old word.
module dm_lane_align
   import dm_lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        sext,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Select the addressed lanes of the word.
   always_comb begin
      byte_lane = word[7:0];
      case (off)
         2'd0: byte_lane = word[7:0];
         2'd1: byte_lane = word[15:8];
         2'd2: byte_lane = word[23:16];
         2'd3: byte_lane = word[31:24];
         default: byte_lane = word[7:0];
      endcase
      half_lane = off[1] ? word[31:16] : word[15:0];
   end

   // Load result: sub-word lanes are sign- or zero-extended, words pass through.
   always_comb begin
      load_data = word;
      case (size)
         SZ_BYTE: load_data = {{24{sext & byte_lane[7]}}, byte_lane};
         SZ_HALF: load_data = {{16{sext & half_lane[15]}}, half_lane};
         default: load_data = word;
      endcase
   end

   // Store merge: the addressed lane takes the low store data, other lanes keep the old word.
   always_comb begin
      merged = word;
      case (size)
         SZ_BYTE: begin
            case (off)
               2'd0: merged[7:0]   = wdata[7:0];
               2'd1: merged[15:8]  = wdata[7:0];
               2'd2: merged[23:16] = wdata[7:0];
               2'd3: merged[31:24] = wdata[7:0];
               default: merged = word;
            endcase
         end
         SZ_HALF: begin
            if (off[1]) merged[31:16] = wdata[15:0];
            else        merged[15:0]  = wdata[15:0];
         end
         default: merged = wdata;
      endcase
   end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit: turns CPU byte/half/word accesses into DM word
// transactions. Sub-word stores are done as read-modify-write.
// Handshake: a request is accepted on a clock edge where req and ready are
// both high; ready is high only while idle, and done pulses for one cycle
// when the access completes, with err and rdata valid in that cycle.
module dm_lsu
   import dm_lsu_pkg::*;
#(
   parameter int          DEPTH    = 100,
   parameter logic [31:0] ERR_CODE = ERR_CODE_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        dm_memwrite,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wd,
   input  logic [31:0] dm_rd
);

   localparam logic [29:0] DEPTH_IDX = 30'(DEPTH);

   lsu_state_t  state;
   lsu_state_t  state_next;

   // Fields latched at accept time.
   logic        lat_we;
   logic [1:0]  lat_size;
   logic        lat_sext;
   logic [1:0]  lat_off;
   logic [31:0] lat_wdata;
   logic        err_q;

   logic        req_err;
   logic        word_store;
   logic [31:0] load_data;
   logic [31:0] merged;

   // Request classification on the raw inputs, used at the accept edge.
   always_comb begin
      req_err    = (size == SZ_ILL) || access_misaligned(size, addr[1:0]) ||
                   (addr[31:2] >= DEPTH_IDX);
      word_store = we && (size == SZ_WORD);
   end

   // READ-cycle word from DM goes straight through the lane logic, so the
   // captured result is already extracted (load) or merged (store).
   dm_lane_align u_align (
      .word      (dm_rd),
      .wdata     (lat_wdata),
      .off       (lat_off),
      .size      (lat_size),
      .sext      (lat_sext),
      .load_data (load_data),
      .merged    (merged)
   );

   // State register; reset in any state abandons the access.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_next  = state;
      ready       = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      dm_memwrite = 1'b0;
      case (state)
         ST_IDLE: begin
            ready = 1'b1;
            if (req) begin
               if (req_err)         state_next = ST_RESP;
               else if (word_store) state_next = ST_WRITE;
               else                 state_next = ST_READ;
            end
         end
         ST_READ:  state_next = lat_we ? ST_WRITE : ST_RESP;
         ST_WRITE: begin
            // Gated by reset so a reset in this cycle suppresses the write.
            dm_memwrite = ~reset;
            state_next  = ST_RESP;
         end
         ST_RESP: begin
            done       = 1'b1;
            err        = err_q;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Datapath registers: accept-time latches, DM address/data, load result.
   always_ff @(posedge clk) begin
      if (reset) begin
         lat_we    <= 1'b0;
         lat_size  <= SZ_BYTE;
         lat_sext  <= 1'b0;
         lat_off   <= 2'b00;
         lat_wdata <= 32'h0;
         err_q     <= 1'b0;
         rdata     <= 32'h0;
         dm_addr   <= 32'h0;
         dm_wd     <= 32'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  lat_we    <= we;
                  lat_size  <= size;
                  lat_sext  <= sext;
                  lat_off   <= addr[1:0];
                  lat_wdata <= wdata;
                  err_q     <= req_err;
                  dm_addr   <= {2'b00, addr[31:2]};
                  if (req_err)         rdata <= ERR_CODE;
                  else if (word_store) dm_wd <= wdata;
               end
            end
            ST_READ: begin
               if (lat_we) dm_wd <= merged;
               else        rdata <= load_data;
            end
            default: ;
         endcase
      end
   end

endmodule
